// File: rtl/wb_multi_retire_if.sv
// Bundle interface between MEM, the write-back stage, the register file and the debug trace port.
interface wb_multi_retire_if #(
  parameter int LANES  = 2,
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic                     flush;
  logic                     stall_self;
  logic                     stall_next;
  logic [LANES-1:0]         mem_valid;
  logic [LANES*32-1:0]      mem_pc;
  logic [LANES*4-1:0]       mem_we;
  logic [LANES*AW-1:0]      mem_waddr;
  logic [LANES*DATA_W-1:0]  mem_wdata;
  logic [LANES*4-1:0]       rf_we;
  logic [LANES*AW-1:0]      rf_waddr;
  logic [LANES*DATA_W-1:0]  rf_wdata;
  logic                     trace_stall_req;
  logic                     trace_overflow;
  logic [31:0]              debug_wb_pc;
  logic [3:0]               debug_wb_rf_wen;
  logic [AW-1:0]            debug_wb_rf_wnum;
  logic [DATA_W-1:0]        debug_wb_rf_wdata;

  modport master (
    output flush, stall_self, stall_next,
           mem_valid, mem_pc, mem_we, mem_waddr, mem_wdata,
    input  rf_we, rf_waddr, rf_wdata, trace_stall_req, trace_overflow,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );

  modport slave (
    input  flush, stall_self, stall_next,
           mem_valid, mem_pc, mem_we, mem_waddr, mem_wdata,
    output rf_we, rf_waddr, rf_wdata, trace_stall_req, trace_overflow,
           debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata
  );
endinterface

// File: rtl/wb_multi_retire.sv
// Multi-lane write-back stage: captures a retiring bundle, drives per-lane RF writes
// and serialises every retirement through an in-order trace FIFO to the debug port.
module wb_multi_retire #(
  parameter int LANES       = 2,
  parameter int DATA_W      = 32,
  parameter int AW          = 5,
  parameter int TRACE_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  wb_multi_retire_if.slave bus
);

  localparam int PW = $clog2(TRACE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0]       pc;
    logic [3:0]        wen;
    logic [AW-1:0]     wnum;
    logic [DATA_W-1:0] wdata;
  } trace_t;

  logic [LANES-1:0]        valid_q, valid_d;
  logic [LANES*32-1:0]     pc_q, pc_d;
  logic [LANES*4-1:0]      we_q, we_d;
  logic [LANES*AW-1:0]     waddr_q, waddr_d;
  logic [LANES*DATA_W-1:0] wdata_q, wdata_d;
  logic                    pushed_q, pushed_d;

  trace_t                  fifo_q [TRACE_DEPTH];
  trace_t                  fifo_d [TRACE_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           occ_q, occ_d;
  logic                    overflow_q, overflow_d;

  logic [LANES*4-1:0]      eff_we;
  logic [LANES-1:0]        lane_kill;
  logic                    pop;
  int                      free_slots;
  int                      n_acc;
  trace_t                  head;

  // A hold marks the bundle as already traced so it is pushed exactly once.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    we_d     = we_q;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    pushed_d = pushed_q;
    if (bus.flush || (bus.stall_self && !bus.stall_next)) begin
      valid_d  = '0;
      pc_d     = '0;
      we_d     = '0;
      waddr_d  = '0;
      wdata_d  = '0;
      pushed_d = 1'b0;
    end else if (!bus.stall_self) begin
      valid_d  = bus.mem_valid;
      pc_d     = bus.mem_pc;
      we_d     = bus.mem_we;
      waddr_d  = bus.mem_waddr;
      wdata_d  = bus.mem_wdata;
      pushed_d = 1'b0;
    end else begin
      pushed_d = 1'b1;
    end
  end

  // A lane loses its write when any higher valid lane targets the same register.
  always_comb begin
    eff_we    = '0;
    lane_kill = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (valid_q[j] && (waddr_q[j*AW +: AW] == waddr_q[i*AW +: AW])) begin
          lane_kill[i] = 1'b1;
        end
      end
      if (valid_q[i] && (waddr_q[i*AW +: AW] != '0) && !lane_kill[i]) begin
        eff_we[i*4 +: 4] = we_q[i*4 +: 4];
      end
    end
  end

  // The same-cycle pop frees a slot, so it counts towards the room for new pushes.
  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    pop        = (occ_q != '0);
    free_slots = TRACE_DEPTH - int'(occ_q) + (pop ? 1 : 0);
    n_acc      = 0;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (!pushed_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (valid_q[i]) begin
          if (n_acc < free_slots) begin
            fifo_d[wr_ptr_q + PW'(n_acc)] = '{pc:    pc_q[i*32 +: 32],
                                              wen:   eff_we[i*4 +: 4],
                                              wnum:  waddr_q[i*AW +: AW],
                                              wdata: wdata_q[i*DATA_W +: DATA_W]};
            n_acc = n_acc + 1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
    wr_ptr_d = wr_ptr_q + PW'(n_acc);
    occ_d    = occ_q + CW'(n_acc) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      pc_q       <= '0;
      we_q       <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      pushed_q   <= 1'b0;
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      pushed_q   <= pushed_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  assign head = (occ_q != '0) ? fifo_q[rd_ptr_q] : '0;

  assign bus.rf_we             = eff_we;
  assign bus.rf_waddr          = waddr_q;
  assign bus.rf_wdata          = wdata_q;
  assign bus.trace_stall_req   = (TRACE_DEPTH - int'(occ_q)) < LANES;
  assign bus.trace_overflow    = overflow_q;
  assign bus.debug_wb_pc       = head.pc;
  assign bus.debug_wb_rf_wen   = head.wen;
  assign bus.debug_wb_rf_wnum  = head.wnum;
  assign bus.debug_wb_rf_wdata = head.wdata;

endmodule

// File: tb/tb_wb_multi_retire.sv
// Testbench for wb_multi_retire: directed scenarios then random traffic, all checked
// against a queue-based reference model of retirement and tracing.
module tb_wb_multi_retire;

  localparam int LANES  = 2;
  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wb_multi_retire_if #(.LANES(LANES), .DATA_W(DATA_W), .AW(AW)) bus ();

  wb_multi_retire #(
    .LANES(LANES), .DATA_W(DATA_W), .AW(AW), .TRACE_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0]       pc;
    logic [3:0]        wen;
    logic [AW-1:0]     wnum;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  int checks = 0;
  int errors = 0;

  entry_t                  mq[$];
  logic [LANES-1:0]        mValid;
  logic [LANES*32-1:0]     mPc;
  logic [LANES*4-1:0]      mWe;
  logic [LANES*AW-1:0]     mWaddr;
  logic [LANES*DATA_W-1:0] mWdata;
  logic                    mPushed;
  logic                    mOverflow;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Highest valid lane wins a shared nonzero register; r0 is never written.
  function automatic logic [LANES*4-1:0] expectedWe();
    logic [LANES*4-1:0] res = '0;
    for (int i = 0; i < LANES; i++) begin
      logic keep = mValid[i] && (mWaddr[i*AW +: AW] != 0);
      for (int j = i + 1; j < LANES; j++)
        if (mValid[j] && mWaddr[j*AW +: AW] == mWaddr[i*AW +: AW]) keep = 1'b0;
      if (keep) res[i*4 +: 4] = mWe[i*4 +: 4];
    end
    return res;
  endfunction

  task automatic modelStep();
    logic [LANES*4-1:0] w;
    if (rst) begin
      mq.delete();
      mValid = '0; mPc = '0; mWe = '0; mWaddr = '0; mWdata = '0;
      mPushed = 1'b0; mOverflow = 1'b0;
      return;
    end
    w = expectedWe();
    if (mq.size() > 0) mq.delete(0);
    if (!mPushed) begin
      for (int i = 0; i < LANES; i++) begin
        if (mValid[i]) begin
          if (mq.size() < DEPTH)
            mq.push_back('{pc: mPc[i*32 +: 32], wen: w[i*4 +: 4],
                           wnum: mWaddr[i*AW +: AW], wdata: mWdata[i*DATA_W +: DATA_W]});
          else
            mOverflow = 1'b1;
        end
      end
    end
    if (bus.flush || (bus.stall_self && !bus.stall_next)) begin
      mValid = '0; mPc = '0; mWe = '0; mWaddr = '0; mWdata = '0;
      mPushed = 1'b0;
    end else if (!bus.stall_self) begin
      mValid = bus.mem_valid; mPc = bus.mem_pc; mWe = bus.mem_we;
      mWaddr = bus.mem_waddr; mWdata = bus.mem_wdata;
      mPushed = 1'b0;
    end else begin
      mPushed = 1'b1;
    end
  endtask

  task automatic checkAll();
    entry_t h = '{pc: '0, wen: '0, wnum: '0, wdata: '0};
    if (mq.size() > 0) h = mq[0];
    checkOutput("rf_we", 64'(bus.rf_we), 64'(expectedWe()));
    checkOutput("rf_waddr", 64'(bus.rf_waddr), 64'(mWaddr));
    checkOutput("rf_wdata", 64'(bus.rf_wdata), 64'(mWdata));
    checkOutput("stall_req", 64'(bus.trace_stall_req), 64'((DEPTH - mq.size()) < LANES));
    checkOutput("overflow", 64'(bus.trace_overflow), 64'(mOverflow));
    checkOutput("dbg_pc", 64'(bus.debug_wb_pc), 64'(h.pc));
    checkOutput("dbg_wen", 64'(bus.debug_wb_rf_wen), 64'(h.wen));
    checkOutput("dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'(h.wnum));
    checkOutput("dbg_wdata", 64'(bus.debug_wb_rf_wdata), 64'(h.wdata));
  endtask

  task automatic applyStimulus(input logic r, input logic fl, input logic ss, input logic sn,
                               input logic [LANES-1:0] v, input logic [LANES*32-1:0] pc,
                               input logic [LANES*4-1:0] we, input logic [LANES*AW-1:0] wa,
                               input logic [LANES*DATA_W-1:0] wd);
    rst = r; bus.flush = fl; bus.stall_self = ss; bus.stall_next = sn;
    bus.mem_valid = v; bus.mem_pc = pc; bus.mem_we = we;
    bus.mem_waddr = wa; bus.mem_wdata = wd;
    @(posedge clk);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, '0, '0, '0, '0, '0);
  endtask

  initial begin
    mq.delete();
    mValid = '0; mPc = '0; mWe = '0; mWaddr = '0; mWdata = '0;
    mPushed = 1'b0; mOverflow = 1'b0;

    applyStimulus(1, 0, 0, 0, '0, '0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, '0, '0, '0);
    checkOutput("reset_rf_we", 64'(bus.rf_we), 64'h0);
    checkOutput("reset_dbg_pc", 64'(bus.debug_wb_pc), 64'h0);

    // Single-lane retire
    applyStimulus(0, 0, 0, 0, 2'b01, {32'h0, 32'hBFC00000}, {4'h0, 4'hF},
                  {5'd0, 5'd3}, {32'h0, 32'h12345678});
    checkOutput("single_rf_we", 64'(bus.rf_we[3:0]), 64'hF);
    idle();
    checkOutput("single_dbg_pc", 64'(bus.debug_wb_pc), 64'hBFC00000);
    checkOutput("single_dbg_wnum", 64'(bus.debug_wb_rf_wnum), 64'd3);
    idle();

    // Dual retire then drain
    applyStimulus(0, 0, 0, 0, 2'b11, {32'h104, 32'h100}, 8'hFF,
                  {5'd5, 5'd4}, {32'hBBBB0002, 32'hAAAA0001});
    checkOutput("dual_rf_we", 64'(bus.rf_we), 64'hFF);
    idle();
    checkOutput("dual_dbg_pc0", 64'(bus.debug_wb_pc), 64'h100);
    idle();
    checkOutput("dual_dbg_pc1", 64'(bus.debug_wb_pc), 64'h104);
    idle();
    checkOutput("dual_dbg_empty", 64'(bus.debug_wb_pc), 64'h0);

    // Same-register conflict, then r0 destination
    applyStimulus(0, 0, 0, 0, 2'b11, {32'h14, 32'h10}, 8'hFF,
                  {5'd7, 5'd7}, {32'h2, 32'h1});
    checkOutput("conflict_rf_we", 64'(bus.rf_we), 64'hF0);
    applyStimulus(0, 0, 0, 0, 2'b01, {32'h0, 32'h200}, 8'h0F,
                  {5'd0, 5'd0}, {32'h0, 32'h5});
    checkOutput("r0_rf_we", 64'(bus.rf_we), 64'h0);
    checkOutput("conflict_dbg_wen0", 64'(bus.debug_wb_rf_wen), 64'h0);
    idle();
    checkOutput("conflict_dbg_wen1", 64'(bus.debug_wb_rf_wen), 64'hF);
    idle();
    checkOutput("r0_dbg_pc", 64'(bus.debug_wb_pc), 64'h200);
    idle();

    // Bubble on stall_self alone; triple hold pushes once
    applyStimulus(0, 0, 1, 0, 2'b01, {32'h0, 32'h280}, 8'h0F, {5'd0, 5'd9}, '0);
    checkOutput("bubble_rf_we", 64'(bus.rf_we), 64'h0);
    applyStimulus(0, 0, 0, 0, 2'b01, {32'h0, 32'h300}, 8'h0F, {5'd0, 5'd9}, {32'h0, 32'h99});
    applyStimulus(0, 0, 1, 1, 2'b11, '1, '1, '1, '1);
    checkOutput("hold_dbg_pc", 64'(bus.debug_wb_pc), 64'h300);
    applyStimulus(0, 0, 1, 1, 2'b11, '1, '1, '1, '1);
    checkOutput("hold_once", 64'(bus.debug_wb_pc), 64'h0);
    applyStimulus(0, 0, 1, 1, 2'b11, '1, '1, '1, '1);
    idle();
    idle();

    // Backpressure and overflow with full bundles every cycle
    for (int k = 0; k < 10; k++)
      applyStimulus(0, 0, 0, 0, 2'b11, {32'h1000 + 32'(8*k) + 32'h4, 32'h1000 + 32'(8*k)},
                    8'hFF, {5'd2, 5'd1}, {32'(k), 32'(k + 100)});
    checkOutput("bp_overflow", 64'(bus.trace_overflow), 64'h1);
    checkOutput("bp_stall_req", 64'(bus.trace_stall_req), 64'h1);

    // Reset with entries queued
    applyStimulus(1, 0, 0, 0, '0, '0, '0, '0, '0);
    checkOutput("rst_dbg_pc", 64'(bus.debug_wb_pc), 64'h0);
    checkOutput("rst_overflow", 64'(bus.trace_overflow), 64'h0);

    // Flush discards the captured bundle while the FIFO keeps draining
    applyStimulus(0, 0, 0, 0, 2'b11, {32'h404, 32'h400}, 8'hFF, {5'd6, 5'd5}, '1);
    applyStimulus(0, 1, 0, 0, 2'b11, {32'h504, 32'h500}, 8'hFF, {5'd6, 5'd5}, '1);
    checkOutput("flush_rf_we", 64'(bus.rf_we), 64'h0);
    checkOutput("flush_dbg_pc", 64'(bus.debug_wb_pc), 64'h400);
    idle();
    checkOutput("flush_drain", 64'(bus.debug_wb_pc), 64'h404);
    idle();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      logic [LANES*AW-1:0] wa;
      for (int l = 0; l < LANES; l++) wa[l*AW +: AW] = AW'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 1) == 0),
                    LANES'($urandom), {$urandom, $urandom}, 8'($urandom), wa,
                    {$urandom, $urandom});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
